// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences the PC register and instruction ROM,
// buffers fetched {pc, instr} pairs in a small FIFO and hands them to decode.
module fetch_ctrl #(
    parameter int          BUF_DEPTH  = 2,
    parameter logic [31:0] HALT_INSTR = 32'h00100073
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pc_current,
    input  logic [31:0] instr,
    output logic [31:0] pc_next,
    output logic        pc_write_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic        halted
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [31:0]        r_bufInstr [BUF_DEPTH];
    logic [31:0]        r_bufPc    [BUF_DEPTH];
    logic [PTR_W-1:0]   r_rdPtr;
    logic [PTR_W-1:0]   r_wrPtr;
    logic [CNT_W-1:0]   r_count;
    logic               w_pop;
    logic               w_push;
    logic               w_flush;
    logic               w_space;

    // Pointers wrap explicitly so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign fetch_valid = (r_count != '0);
    assign fetch_instr = r_bufInstr[r_rdPtr];
    assign fetch_pc    = r_bufPc[r_rdPtr];
    assign halted      = (r_state == HALT);
    assign w_pop       = fetch_valid && fetch_ready;
    assign w_space     = (r_count < CNT_W'(BUF_DEPTH)) || w_pop;

    always_comb begin
        w_nextState     = r_state;
        pc_next         = pc_current;
        pc_write_enable = 1'b0;
        w_push          = 1'b0;
        w_flush         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    w_flush         = 1'b1;
                    pc_write_enable = 1'b1;
                    pc_next         = redirect_target & 32'hFFFF_FFFC;
                end else if (w_space) begin
                    w_push = 1'b1;
                    if (instr == HALT_INSTR) begin
                        w_nextState = HALT;
                    end else begin
                        pc_write_enable = 1'b1;
                        pc_next         = pc_current + 32'd4;
                    end
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    w_flush         = 1'b1;
                    pc_write_enable = 1'b1;
                    pc_next         = redirect_target & 32'hFFFF_FFFC;
                    w_nextState     = RUN;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A flush wins over any pop or push in the same cycle; the popped head is
    // already consumed by decode, so dropping the whole buffer is safe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_bufInstr[i] <= '0;
                r_bufPc[i]    <= '0;
            end
        end else if (w_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_bufInstr[r_wrPtr] <= instr;
                r_bufPc[r_wrPtr]    <= pc_current;
                r_wrPtr             <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl: models the PC register and a word ROM
// around the controller and checks handshake, stall, redirect, halt and reset.
module tb_fetch_ctrl;

    localparam logic [31:0] HALT_WORD = 32'h00100073;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pcReg = 32'd0;
    logic [31:0] instr;
    logic [31:0] pcNext;
    logic        pcWe;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectTarget = 32'd0;
    logic        fetchValid;
    logic        fetchReady = 1'b0;
    logic [31:0] fetchInstr;
    logic [31:0] fetchPc;
    logic        halted;
    logic [31:0] rom [64];

    int checks = 0;
    int failures = 0;

    fetch_ctrl #(
        .BUF_DEPTH (2),
        .HALT_INSTR(HALT_WORD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .pc_current     (pcReg),
        .instr          (instr),
        .pc_next        (pcNext),
        .pc_write_enable(pcWe),
        .redirect_valid (redirectValid),
        .redirect_target(redirectTarget),
        .fetch_valid    (fetchValid),
        .fetch_ready    (fetchReady),
        .fetch_instr    (fetchInstr),
        .fetch_pc       (fetchPc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // PC register and combinational ROM that the controller drives.
    always @(posedge clk) begin
        if (reset) begin
            pcReg <= 32'd0;
        end else if (pcWe) begin
            pcReg <= pcNext;
        end
    end

    always_comb begin
        instr = (pcReg < 32'd256) ? rom[pcReg[7:2]] : 32'h0000_0013;
    end

    function automatic logic [31:0] word(input int idx);
        return 32'hA000_0000 + 32'(idx);
    endfunction

    task automatic applyStimulus(input logic rst, input logic st, input logic rv,
                                 input logic [31:0] rt, input logic rdy);
        @(negedge clk);
        reset          = rst;
        start          = st;
        redirectValid  = rv;
        redirectTarget = rt;
        fetchReady     = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom[i] = word(i);
        end

        $display("[TB] reset state");
        doReset();
        checkOutput("rst_valid", 32'(fetchValid), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_we", 32'(pcWe), 32'd0);
        checkOutput("rst_instr", fetchInstr, 32'd0);
        checkOutput("rst_pc", fetchPc, 32'd0);
        checkOutput("rst_pcnext", pcNext, 32'd0);

        $display("[TB] straight-line fetch");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("sl_idle_we", 32'(pcWe), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("sl_first_valid", 32'(fetchValid), 32'd0);
        checkOutput("sl_first_we", 32'(pcWe), 32'd1);
        checkOutput("sl_first_pcnext", pcNext, 32'd4);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
            checkOutput("sl_valid", 32'(fetchValid), 32'd1);
            checkOutput("sl_pc", fetchPc, 32'(4 * k));
            checkOutput("sl_instr", fetchInstr, word(k));
            checkOutput("sl_we", 32'(pcWe), 32'd1);
            checkOutput("sl_pcnext", pcNext, 32'(4 * k + 8));
        end

        $display("[TB] back-pressure");
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("bp_we0", 32'(pcWe), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("bp_we1", 32'(pcWe), 32'd1);
        checkOutput("bp_pcnext1", pcNext, 32'd8);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
            checkOutput("bp_full_we", 32'(pcWe), 32'd0);
            checkOutput("bp_full_pcnext", pcNext, 32'd8);
            checkOutput("bp_full_head", fetchPc, 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
            checkOutput("bp_drain_valid", 32'(fetchValid), 32'd1);
            checkOutput("bp_drain_pc", fetchPc, 32'(4 * k));
            checkOutput("bp_drain_instr", fetchInstr, word(k));
        end

        $display("[TB] redirect and PC wrap");
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0043, 1'b0);
        checkOutput("rd_we", 32'(pcWe), 32'd1);
        checkOutput("rd_pcnext", pcNext, 32'h0000_0040);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("rd_flush_valid", 32'(fetchValid), 32'd0);
        checkOutput("rd_pcnext2", pcNext, 32'h0000_0044);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("rd_head_pc", fetchPc, 32'h0000_0040);
        checkOutput("rd_head_instr", fetchInstr, word(16));
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        checkOutput("wrap_target", pcNext, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("wrap_valid", 32'(fetchValid), 32'd0);
        checkOutput("wrap_pcnext", pcNext, 32'd0);

        $display("[TB] halt and resume");
        rom[3] = HALT_WORD;
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
            checkOutput("ht_pc", fetchPc, 32'(4 * k));
        end
        checkOutput("ht_push_we", 32'(pcWe), 32'd0);
        checkOutput("ht_push_pcnext", pcNext, 32'd12);
        checkOutput("ht_not_yet", 32'(halted), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("ht_halted", 32'(halted), 32'd1);
        checkOutput("ht_last_pc", fetchPc, 32'd12);
        checkOutput("ht_last_instr", fetchInstr, HALT_WORD);
        checkOutput("ht_we", 32'(pcWe), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("ht_drained", 32'(fetchValid), 32'd0);
        checkOutput("ht_pc_hold", pcNext, 32'd12);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("ht_start_ignored", 32'(halted), 32'd1);
        checkOutput("ht_start_we", 32'(pcWe), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b1);
        checkOutput("ht_redir_we", 32'(pcWe), 32'd1);
        checkOutput("ht_redir_pcnext", pcNext, 32'h0000_0020);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("ht_resumed", 32'(halted), 32'd0);
        checkOutput("ht_resume_pcnext", pcNext, 32'h0000_0024);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("ht_resume_pc", fetchPc, 32'h0000_0020);
        checkOutput("ht_resume_instr", fetchInstr, word(8));
        rom[3] = word(3);

        $display("[TB] pop and push at full");
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, (k % 2 == 0));
            checkOutput("pp_head", fetchPc, 32'(4 * ((k + 1) / 2)));
            checkOutput("pp_we", 32'(pcWe), (k % 2 == 0) ? 32'd1 : 32'd0);
        end

        $display("[TB] reset mid-run");
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("mr_full_valid", 32'(fetchValid), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("mr_valid", 32'(fetchValid), 32'd0);
        checkOutput("mr_we", 32'(pcWe), 32'd0);
        checkOutput("mr_halted", 32'(halted), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b1);
        checkOutput("mr_idle_redir_we", 32'(pcWe), 32'd0);
        checkOutput("mr_idle_pcnext", pcNext, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("mr_start_we", 32'(pcWe), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("mr_run_we", 32'(pcWe), 32'd1);
        checkOutput("mr_run_pcnext", pcNext, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that sequences the program counter register and the combinational instruction ROM. It computes the next PC and the PC write enable, captures each fetched instruction with its address into a small in-order buffer, and presents them to decode over a valid/ready handshake. It also handles start-up, back-pressure stalls, redirects (branch/jump targets) and halt-on-EBREAK. It sits between `pc`/`instr_rom` and the decode stage.

## Interface
- `BUF_DEPTH`, 2: number of fetch-buffer entries (2..4).
- `HALT_INSTR`, 32'h00100073: instruction encoding that halts fetch (EBREAK).
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: level; leaves IDLE when sampled high.
- `pc_current` input 32: PC register output (drives ROM `addr`).
- `instr` input 32: ROM output for `pc_current` (combinational, same cycle).
- `pc_next` output 32: next-PC value to the PC register.
- `pc_write_enable` output 1: PC register load enable.
- `redirect_valid` input 1: one-cycle redirect request.
- `redirect_target` input 32: redirect address; bits [1:0] ignored and forced to 0.
- `fetch_valid` output 1: buffer head valid.
- `fetch_ready` input 1: decode accepts head.
- `fetch_instr` output 32: head instruction.
- `fetch_pc` output 32: head instruction address.
- `halted` output 1: controller in HALT.

## Operation
- States: IDLE, RUN, HALT. Reset enters IDLE and clears the buffer (count=0, pointers=0).
- IDLE: no fetch; `pc_write_enable`=0. `start`=1 -> RUN (next cycle).
- RUN, per cycle, priority order:
  1. `redirect_valid`=1: flush the buffer (count->0). Drive `pc_write_enable`=1 and `pc_next`={`redirect_target`[31:2],2'b00}. No push this cycle.
  2. Otherwise, if there is space: push {`pc_current`, `instr`}. Drive `pc_write_enable`=1 and `pc_next`=`pc_current`+4 (mod 2^32, wraps FFFFFFFC->0). If `instr`==`HALT_INSTR`, push it, drive `pc_write_enable`=0, and go to HALT.
  3. Otherwise (no space): stall. `pc_write_enable`=0 and the PC holds.
- Space means count<`BUF_DEPTH`, or count==`BUF_DEPTH` with a pop this cycle. Push and pop in the same cycle leave count unchanged.
- Pop occurs when `fetch_valid`&&`fetch_ready`.
- `fetch_valid`=(count!=0). `fetch_instr`/`fetch_pc` come from the head entry and are registered storage, not combinational from `instr`.
- HALT: no push; `pc_write_enable`=0. The buffer drains normally. `redirect_valid`=1 -> flush, load target, RUN. `start` is ignored in HALT.
- IDLE: `redirect_valid` is ignored.
- When `pc_write_enable`=0, `pc_next`=`pc_current`.
- Redirect in the same cycle as a pop: the handshake completes (decode has consumed the head), then the flush empties the buffer.
- Buffer is a circular FIFO with wrapping read/write pointers; order is strictly preserved.

## Timing
- Reset values: `pc_write_enable`=0, `fetch_valid`=0, `halted`=0, `fetch_instr`=0, `fetch_pc`=0, `pc_next`=`pc_current`.
- `pc_next`, `pc_write_enable` are combinational from state, count, `fetch_ready`, redirect and `instr`. They must be settled before the edge on which the PC loads.
- Fetch latency: the instruction at `pc_current` in cycle N is visible as buffer head in cycle N+1 (if the buffer was empty).
- Throughput: 1 instruction/cycle with `fetch_ready` held high.
- Redirect: target appears on `pc_current` at N+1, and its instruction is at the head at N+2. No wrong-path entry is ever valid after N.
- Start: `start` high in cycle N (IDLE) -> RUN at N+1 -> first push at the end of N+1.
- `halted` rises the cycle after the halt instruction is pushed.
- Reset mid-operation overrides everything: buffer cleared, IDLE next cycle.

## Test plan
- Straight-line: PC reset to 0, ROM words 0..5 distinct, `start`=1, `fetch_ready`=1 -> pairs (0,w0),(4,w1),(8,w2)… one per cycle starting 2 cycles after `start`; `pc_write_enable` high every RUN cycle.
- Back-pressure: `BUF_DEPTH`=2, `fetch_ready`=0 for 5 cycles -> count saturates at 2 and `pc_write_enable`=0 while full. PC holds at 8. Releasing ready delivers 0,4,8 with no loss or duplicate.
- Redirect: `redirect_valid`=1 with target 32'h00000043 while the buffer holds 2 entries -> `fetch_valid`=0 next cycle, `pc_next`=32'h40, first delivered PC is 0x40.
- Halt: ROM[3]=32'h00100073 -> delivers PCs 0,4,8,12, then `halted`=1 and the PC stays at 12. Redirect to 0x20 -> resumes at 0x20, `halted`=0.
- Simultaneous pop+push at full: ready toggling 1/0 at depth 2 -> count never exceeds 2, order preserved.
- Reset mid-run: reset asserted with 2 entries buffered -> next cycle `fetch_valid`=0, IDLE, `pc_write_enable`=0 until `start`.
